// File: rtl/sfifo_if.sv
// Handshake bundle between a producer/consumer pair and the sfifo buffer.
// The master side drives requests and write data; the slave side returns data and status.
interface sfifo_if #(
    parameter int unsigned DATA_W = 4
) ();
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              full;
    logic              empty;

    modport master (
        output wr_en,
        output rd_en,
        output din,
        input  dout,
        input  full,
        input  empty
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  din,
        output dout,
        output full,
        output empty
    );
endinterface

// File: rtl/sfifo.sv
// Single-clock FIFO with registered read data (no fall-through) and count-decoded flags.
// rst_n keeps its legacy name but is an asynchronous active-high reset.
module sfifo #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input logic   clk,
    input logic   rst_n,
    sfifo_if.slave bus
);
    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic empty_flag;
    logic full_flag;
    logic we;
    logic re;

    always_comb begin
        empty_flag = (count_q == '0);
        full_flag  = (count_q == FullCount);
        // A read in the same cycle frees the slot, so a write into a full FIFO is still taken.
        we = bus.wr_en & (~full_flag | bus.rd_en);
        re = bus.rd_en & ~empty_flag;
    end

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (we) begin
            wp_d = wp_q + ADDR_W'(1);
        end
        if (re) begin
            rp_d   = rp_q + ADDR_W'(1);
            dout_d = mem[rp_q];
        end
        case ({we, re})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is never cleared; any write landing during reset is orphaned by the pointer reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wp_q] <= bus.din;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.full  = full_flag;
    assign bus.empty = empty_flag;
endmodule

// File: tb/tb_sfifo.sv
// Directed and randomized bench for sfifo against a queue-based occupancy/ordering model.
// Inputs change just after the falling edge; outputs are checked on the following falling edge.
module tb_sfifo;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 8;

    logic clk;
    logic rst_n;

    sfifo_if #(.DATA_W(DATA_W)) bus ();

    sfifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: queued words in arrival order plus the last word handed out.
    logic [DATA_W-1:0] q [$];
    logic [DATA_W-1:0] dout_m;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".dout"}, bus.dout, dout_m);
        check({tag, ".full"}, {3'b0, bus.full}, {3'b0, q.size() == DEPTH});
        check({tag, ".empty"}, {3'b0, bus.empty}, {3'b0, q.size() == 0});
    endtask

    task automatic model_reset();
        q.delete();
        dout_m = '0;
    endtask

    // One clock cycle with the given requests; the model advances on the rising edge.
    task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d,
                        input string tag);
        bit can_wr;
        bit can_rd;
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.din   = d;
        @(posedge clk);
        can_rd = rd && (q.size() > 0);
        can_wr = wr && ((q.size() < DEPTH) || rd);
        if (rst_n) begin
            can_rd = 1'b0;
            can_wr = 1'b0;
        end
        if (can_rd) dout_m = q.pop_front();
        if (can_wr) q.push_back(d);
        @(negedge clk);
        check_model(tag);
    endtask

    // Reset pulse between edges, spanning one rising edge with random requests applied.
    task automatic reset_pulse(input string tag);
        bus.wr_en = 1'($urandom);
        bus.rd_en = 1'($urandom);
        bus.din   = DATA_W'($urandom);
        #2 rst_n = 1'b1;
        model_reset();
        #1;
        check_model({tag, ".async"});
        #9 rst_n = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        model_reset();

        // Reset held for 10 cycles with random traffic.
        #1 rst_n = 1'b1;
        #1;
        check_model("rst0");
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom), 1'($urandom), DATA_W'($urandom), "rst_hold");
        end
        rst_n = 1'b0;
        step(1'b0, 1'b0, '0, "rst_release");
        check("rst_release.empty_const", {3'b0, bus.empty}, 4'd1);
        check("rst_release.dout_const", bus.dout, 4'd0);

        // Fill 1..8 then drain in order.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DATA_W'(i), "fill");
        check("fill.full_const", {3'b0, bus.full}, 4'd1);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, '0, "drain");
            check("drain.order", bus.dout, DATA_W'(i));
        end
        check("drain.empty_const", {3'b0, bus.empty}, 4'd1);

        // Overflow write of 15 is dropped.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DATA_W'(i), "refill");
        step(1'b1, 1'b0, 4'd15, "overflow");
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, '0, "ovf_drain");
            check("ovf_drain.order", bus.dout, DATA_W'(i));
        end

        // Underflow: dout holds 8.
        step(1'b0, 1'b1, '0, "underflow");
        check("underflow.hold", bus.dout, 4'd8);

        // Empty with read+write: only the write lands.
        step(1'b1, 1'b1, 4'd5, "empty_rw");
        check("empty_rw.hold", bus.dout, 4'd8);
        check("empty_rw.not_empty", {3'b0, bus.empty}, 4'd0);
        step(1'b0, 1'b1, '0, "empty_rw_read");
        check("empty_rw_read.data", bus.dout, 4'd5);

        // Full with read+write: oldest out, 9 in, still full.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, DATA_W'(i), "fill2");
        step(1'b1, 1'b1, 4'd9, "full_rw");
        check("full_rw.oldest", bus.dout, 4'd1);
        check("full_rw.full", {3'b0, bus.full}, 4'd1);
        for (int i = 2; i <= 9; i++) begin
            step(1'b0, 1'b1, '0, "full_rw_drain");
            check("full_rw_drain.order", bus.dout, DATA_W'(i));
        end

        // Interleaved traffic, occupancy 0..3, pointers wrap past the top.
        for (int i = 0; i < 20; i++) begin
            if ((i % 6) < 3) step(1'b1, 1'b0, DATA_W'($urandom), "wrap_wr");
            else step(1'b0, 1'b1, '0, "wrap_rd");
        end

        // Mid-stream reset discards queued words.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DATA_W'(i + 1), "pre_rst");
        reset_pulse("mid_rst");
        step(1'b1, 1'b0, 4'hA, "post_rst_wr");
        step(1'b0, 1'b1, '0, "post_rst_rd");
        check("post_rst_rd.new_data", bus.dout, 4'hA);
        check("post_rst_rd.empty", {3'b0, bus.empty}, 4'd1);

        // Random soak with two asynchronous reset pulses.
        for (int i = 0; i < 100; i++) begin
            if (i == 33 || i == 66) reset_pulse("soak_rst");
            step(1'($urandom), 1'($urandom), DATA_W'($urandom), "soak");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
